// File: rtl/imm_pkg.sv
// Shared constants for the immediate decode stage: RV32I opcodes,
// one-hot format bit positions and the format vector width.
package imm_pkg;

    localparam int FMT_W = 6;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // One-hot format vector with a single bit set at position idx.
    function automatic logic [FMT_W-1:0] fmt_onehot(input int idx);
        logic [FMT_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational opcode decode and RV32I immediate generation.
// The illegal-opcode output exists only when IMM_DECODE_ILLEGAL_EN is defined.
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      inst,
    output logic [FMT_W-1:0] format,
    output logic [XLEN-1:0]  immediate
`ifdef IMM_DECODE_ILLEGAL_EN
    ,
    output logic             illegal
`endif
);

    logic [31:0] imm32;
    logic        bad_opc;

    // Select format and assemble the 32-bit immediate from the opcode.
    always_comb begin
        format  = '0;
        imm32   = 32'h0000_0000;
        bad_opc = 1'b0;
        case (inst[6:0])
            OPC_OP: begin
                format = fmt_onehot(FMT_R);
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                format = fmt_onehot(FMT_I);
                imm32  = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                format = fmt_onehot(FMT_S);
                imm32  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                format = fmt_onehot(FMT_B);
                imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                format = fmt_onehot(FMT_U);
                imm32  = {inst[31:12], 12'h000};
            end
            OPC_JAL: begin
                format = fmt_onehot(FMT_J);
                imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                bad_opc = 1'b1;
            end
        endcase
    end

    // Every 32-bit immediate already carries inst[31] in bit 31; widen signed.
    assign immediate = XLEN'($signed(imm32));

`ifdef IMM_DECODE_ILLEGAL_EN
    assign illegal = bad_opc;
`else
    logic unused_bad_opc;
    assign unused_bad_opc = bad_opc;
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes on the input side, buffers decoded
// entries in a DEPTH-entry circular FIFO and presents the head from
// output registers (1-cycle latency, no input-to-output combinational path).
// Optional feature macro: IMM_DECODE_ILLEGAL_EN (stores and reports o_illegal).
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [FMT_W-1:0] o_format,
    output logic [XLEN-1:0]  o_immediate,
    output logic [31:0]      o_inst,
    output logic             o_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s;
    logic [CW-1:0]    count_r, count_next_s;
    logic             push_s, pop_s, accept_s, head_new_s;

    logic [FMT_W-1:0] gen_format_s;
    logic [XLEN-1:0]  gen_imm_s;

    logic [FMT_W-1:0] fmt_mem [DEPTH];
    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic [FMT_W-1:0] head_fmt_s;
    logic [XLEN-1:0]  head_imm_s;
    logic [31:0]      head_inst_s;

`ifdef IMM_DECODE_ILLEGAL_EN
    logic gen_illegal_s;
    logic ill_mem [DEPTH];
    logic head_ill_s;
`endif

    imm_gen #(.XLEN(XLEN)) u_gen (
        .inst      (i_inst),
        .format    (gen_format_s),
        .immediate (gen_imm_s)
`ifdef IMM_DECODE_ILLEGAL_EN
        ,
        .illegal   (gen_illegal_s)
`endif
    );

    assign o_ready  = (count_r != CW'(DEPTH));
    assign push_s   = i_valid & o_ready;
    assign pop_s    = o_valid & i_ready;
    assign accept_s = push_s & ~i_flush;

    // Next pointers and occupancy; flush empties the buffer and drops any push/pop.
    always_comb begin
        rd_next_s    = rd_ptr_r;
        wr_next_s    = wr_ptr_r;
        count_next_s = count_r;
        if (i_flush) begin
            rd_next_s    = '0;
            wr_next_s    = '0;
            count_next_s = '0;
        end else begin
            if (push_s) begin
                wr_next_s = wr_ptr_r + PW'(1);
            end else begin
                wr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_next_s = rd_ptr_r + PW'(1);
            end else begin
                rd_next_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // The next head is the entry being written this cycle when it lands in the head slot.
    assign head_new_s = accept_s & (wr_ptr_r == rd_next_s);

    // Pick the entry the output registers will present next cycle.
    always_comb begin
        head_fmt_s  = fmt_mem[rd_next_s];
        head_imm_s  = imm_mem[rd_next_s];
        head_inst_s = inst_mem[rd_next_s];
        if (head_new_s) begin
            head_fmt_s  = gen_format_s;
            head_imm_s  = gen_imm_s;
            head_inst_s = i_inst;
        end else begin
            head_fmt_s  = fmt_mem[rd_next_s];
            head_imm_s  = imm_mem[rd_next_s];
            head_inst_s = inst_mem[rd_next_s];
        end
    end

    // Entry storage written at the write pointer on an accepted push.
    always_ff @(posedge i_clk) begin
        if (accept_s && !i_rst) begin
            fmt_mem[wr_ptr_r]  <= gen_format_s;
            imm_mem[wr_ptr_r]  <= gen_imm_s;
            inst_mem[wr_ptr_r] <= i_inst;
        end
    end

    // Pointer/count state and registered head outputs; payload holds when empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            o_valid     <= 1'b0;
            o_format    <= '0;
            o_immediate <= '0;
            o_inst      <= 32'h0000_0000;
        end else begin
            rd_ptr_r <= rd_next_s;
            wr_ptr_r <= wr_next_s;
            count_r  <= count_next_s;
            o_valid  <= (count_next_s != CW'(0));
            if (count_next_s != CW'(0)) begin
                o_format    <= head_fmt_s;
                o_immediate <= head_imm_s;
                o_inst      <= head_inst_s;
            end
        end
    end

`ifdef IMM_DECODE_ILLEGAL_EN
    // Per-entry illegal flag storage.
    always_ff @(posedge i_clk) begin
        if (accept_s && !i_rst) begin
            ill_mem[wr_ptr_r] <= gen_illegal_s;
        end
    end

    assign head_ill_s = head_new_s ? gen_illegal_s : ill_mem[rd_next_s];

    // Registered illegal flag following the same head selection as the payload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_illegal <= 1'b0;
        end else if (count_next_s != CW'(0)) begin
            o_illegal <= head_ill_s;
        end
    end
`else
    assign o_illegal = 1'b0;
`endif

endmodule
